// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window controller.
// Window element (r,c) sits at slice idx(r,c); r=0 is the oldest row, c=0 the oldest column.
package sobel_pkg;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  localparam int DEF_DW = 8;
  localparam int WIN_N  = 9;

  function automatic int idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/sobel_window_regs.sv
// 3x3 pixel window: three columns of three rows, shifted left on shift_en
// with the new column loaded on the right (c=2).
module sobel_window_regs
  import sobel_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic [2:0][DW-1:0]    col_in,
  output logic [WIN_N*DW-1:0]   win_o
);

  logic [2:0][2:0][DW-1:0] w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w <= '0;
    end else if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        w[r] <= {col_in[r], w[r][2], w[r][1]};
      end
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign win_o[DW*idx(r, c) +: DW] = w[r][c];
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sequencing controller for the Sobel two-line buffer: accepts a raster stream,
// drives the line-buffer write, and emits interior 3x3 windows with valid/ready.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = DEF_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                pix_valid_i,
  input  logic [DW-1:0]       pix_data_i,
  output logic                pix_ready_o,
  output logic                lb_we_o,
  output logic [DW-1:0]       lb_data_o,
  input  logic [DW-1:0]       lb_data0_i,
  input  logic [DW-1:0]       lb_data1_i,
  input  logic [DW-1:0]       lb_data2_i,
  output logic                win_valid_o,
  output logic [WIN_N*DW-1:0] win_o,
  input  logic                win_ready_i,
  output logic                busy_o,
  output logic                frame_done_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          win_vld;
  logic          fdone;
  logic          accept;
  logic          row_end;
  logic          qual;

  assign pix_ready_o  = ((state == FILL) || (state == RUN)) && (!win_vld || win_ready_i);
  assign accept       = pix_valid_i && pix_ready_o;
  assign row_end      = (col == COL_LAST);
  // Columns 0/1 would straddle the row wrap, so only col>=2 yields a window.
  assign qual         = accept && (state == RUN) && (col >= CW'(2));

  assign lb_we_o      = accept;
  assign lb_data_o    = pix_data_i;
  assign win_valid_o  = win_vld;
  assign busy_o       = (state != IDLE);
  assign frame_done_o = fdone;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      win_vld <= 1'b0;
      fdone   <= 1'b0;
    end else begin
      fdone <= 1'b0;
      if (accept) begin
        if (row_end) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (qual)
        win_vld <= 1'b1;
      else if (win_ready_i)
        win_vld <= 1'b0;
      case (state)
        IDLE: begin
          // The frame_done cycle is already IDLE; start is deferred one cycle.
          if (start_i && !fdone) begin
            state <= FILL;
            col   <= '0;
            row   <= '0;
          end
        end
        FILL:  if (accept && row_end && (row == RW'(1))) state <= RUN;
        RUN:   if (accept && row_end && (row == ROW_LAST)) state <= DRAIN;
        DRAIN: begin
          if (!win_vld || win_ready_i) begin
            state <= IDLE;
            fdone <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sobel_window_regs #(.DW(DW)) u_win (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .col_in   ({lb_data0_i, lb_data1_i, lb_data2_i}),
    .win_o    (win_o)
  );

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 5x4 frame of pixels 0..19,
// with a behavioural two-line buffer supplying the taps.
module tb_sobel_window_ctrl;
  import sobel_pkg::*;

  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int DW    = 8;
  localparam int WW    = 9 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic          pix_valid_i = 1'b0;
  logic [DW-1:0] pix_data_i = '0;
  logic          win_ready_i = 1'b1;
  logic          pix_ready_o, lb_we_o, win_valid_o, busy_o, frame_done_o;
  logic [DW-1:0] lb_data_o, tap0, tap1, tap2;
  logic [WW-1:0] win_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sobel_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .pix_valid_i  (pix_valid_i),
    .pix_data_i   (pix_data_i),
    .pix_ready_o  (pix_ready_o),
    .lb_we_o      (lb_we_o),
    .lb_data_o    (lb_data_o),
    .lb_data0_i   (tap0),
    .lb_data1_i   (tap1),
    .lb_data2_i   (tap2),
    .win_valid_o  (win_valid_o),
    .win_o        (win_o),
    .win_ready_i  (win_ready_i),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  // Two IMG_W-deep delay lines: taps are row-1 and row-2 at the same column.
  logic [DW-1:0] d1 [IMG_W];
  logic [DW-1:0] d2 [IMG_W];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IMG_W; i++) begin
        d1[i] <= '0;
        d2[i] <= '0;
      end
    end else if (lb_we_o) begin
      d1[0] <= lb_data_o;
      d2[0] <= d1[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        d1[i] <= d1[i-1];
        d2[i] <= d2[i-1];
      end
    end
  end
  assign tap0 = lb_data_o;
  assign tap1 = d1[IMG_W-1];
  assign tap2 = d2[IMG_W-1];

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected window k of a frame: anchored on pixels 12,13,14,17,18,19.
  function automatic logic [WW-1:0] exp_win(input int k);
    int plist[6] = '{12, 13, 14, 17, 18, 19};
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[DW*idx(r, c) +: DW] = DW'(plist[k] - 12 + 5 * r + c);
    return w;
  endfunction

  // Monitor: sample at negedge, record completed window handshakes.
  logic [WW-1:0] wq[$];
  int cyc = 0;
  int acc12_cyc, first_win_cyc, fd_cnt, stall_cyc, stall_bad, hold_bad;
  bit prev_stall = 1'b0;
  logic [WW-1:0] prev_win = '0;
  bit rdy_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    win_ready_i = rdy_mode ? !win_ready_i : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (lb_we_o && lb_data_o == 8'd12 && acc12_cyc < 0) acc12_cyc = cyc;
      if (win_valid_o && first_win_cyc < 0) first_win_cyc = cyc;
      if (win_valid_o && win_ready_i) wq.push_back(win_o);
      if (frame_done_o) fd_cnt++;
      if (prev_stall && (!win_valid_o || win_o !== prev_win)) hold_bad++;
      if (win_valid_o && !win_ready_i) begin
        stall_cyc++;
        if (pix_ready_o) stall_bad++;
      end
      prev_stall = win_valid_o && !win_ready_i;
      prev_win   = win_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_mon();
    wq.delete();
    acc12_cyc = -1;
    first_win_cyc = -1;
    fd_cnt = 0;
    stall_cyc = 0;
    stall_bad = 0;
    hold_bad = 0;
  endtask

  task automatic start_frame();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_pix(input int p, input bit gaps);
    bit acc = 1'b0;
    int guard = 0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        pix_valid_i = 1'b0;
        @(posedge clk); #1;
      end
    end
    pix_valid_i = 1'b1;
    pix_data_i  = DW'(p);
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = pix_ready_o;
      guard++;
      @(posedge clk); #1;
    end
    pix_valid_i = 1'b0;
    if (!acc) chk($sformatf("pix%0d_timeout", p), 0, 1);
  endtask

  task automatic send_frame(input bit gaps);
    for (int p = 0; p < IMG_W * IMG_H; p++) send_pix(p, gaps);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (fd_cnt == 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_nwin"}, wq.size(), 6);
    for (int k = 0; k < 6 && k < wq.size(); k++)
      chk($sformatf("%s_win%0d", tag, k), wq[k], exp_win(k));
    chk({tag, "_fdone_cnt"}, fd_cnt, 1);
    chk({tag, "_hold"}, hold_bad, 0);
    chk({tag, "_busy_end"}, busy_o, 0);
  endtask

  initial begin
    logic [WW-1:0] w;
    clear_mon();

    // Reset state
    pix_data_i  = 8'hA5;
    pix_valid_i = 1'b1;
    #2;
    chk("rst_pix_ready", pix_ready_o, 0);
    chk("rst_lb_we", lb_we_o, 0);
    chk("rst_lb_data", lb_data_o, 8'hA5);
    chk("rst_win_valid", win_valid_o, 0);
    chk("rst_win", win_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_fdone", frame_done_o, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // pix_valid in IDLE is not accepted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle_ready%0d", i), pix_ready_o, 0);
      chk($sformatf("idle_we%0d", i), lb_we_o, 0);
    end
    @(posedge clk); #1;
    pix_valid_i = 1'b0;

    // Full-rate frame, ready always high
    clear_mon();
    start_frame();
    @(negedge clk);
    chk("start_busy", busy_o, 1);
    chk("start_ready", pix_ready_o, 1);
    @(posedge clk); #1;
    send_frame(1'b0);
    wait_done();
    check_frame("s1");
    chk("s1_latency", first_win_cyc, acc12_cyc + 1);
    w = (wq.size() > 0) ? wq[0] : '1;
    chk("s1_first_p0", w[7:0], 8'd0);
    w = (wq.size() > 0) ? wq[0] : '1;
    chk("s1_first_p4", w[39:32], 8'd6);
    chk("s1_first_p8", w[71:64], 8'd12);
    w = (wq.size() > 0) ? wq[wq.size()-1] : '1;
    chk("s1_last_centre", w[39:32], 8'd13);

    // Downstream ready toggling
    clear_mon();
    rdy_mode = 1'b1;
    start_frame();
    send_frame(1'b0);
    wait_done();
    rdy_mode = 1'b0;
    check_frame("s2");
    chk("s2_stalls_seen", stall_cyc > 0, 1);
    chk("s2_stall_blocks_input", stall_bad, 0);

    // Random input gaps
    clear_mon();
    start_frame();
    send_frame(1'b1);
    wait_done();
    check_frame("s3");

    // Reset mid-frame at pixel 8, then a clean frame
    clear_mon();
    start_frame();
    for (int p = 0; p < 8; p++) send_pix(p, 1'b0);
    pix_valid_i = 1'b1;
    pix_data_i  = 8'd8;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", pix_ready_o, 0);
    chk("mid_rst_we", lb_we_o, 0);
    chk("mid_rst_win_valid", win_valid_o, 0);
    chk("mid_rst_win", win_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_fdone", frame_done_o, 0);
    pix_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    clear_mon();
    start_frame();
    send_frame(1'b0);
    wait_done();
    check_frame("s4");

    // start held high through DRAIN and frame_done
    clear_mon();
    start_frame();
    send_frame(1'b0);
    start_i = 1'b1;
    for (int g = 0; g < 50 && !frame_done_o; g++) @(negedge clk);
    chk("s5_fdone_seen", frame_done_o, 1);
    chk("s5_busy_at_fdone", busy_o, 0);
    @(negedge clk);
    chk("s5_busy_idle", busy_o, 0);
    chk("s5_fdone_single", frame_done_o, 0);
    @(negedge clk);
    chk("s5_busy_restart", busy_o, 1);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("s5_fdone_cnt", fd_cnt, 1);
    clear_mon();
    send_frame(1'b0);
    wait_done();
    check_frame("s5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
